// File: rtl/alu_pipe_param.sv
// alu_pipe_param: three-stage, flow-controlled pipelined ALU.
//   S1 registers the operands, S2 executes and registers result/flags/err,
//   and S3 is the output register that drives every out_* port.
//   Each stage holds a valid bit. The ready chain is combinational, so the
//   pipeline has no bubbles and sustains one operation per clock.
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake for op_code, a, b, in_tag
//   out_valid/out_ready  output handshake for result, flags, out_err, out_tag
//   result               WIDTH-bit result, which wraps modulo 2^WIDTH
//   flag_z/n/c/v         zero, negative, carry/borrow/shifted-out, overflow
//   out_err              the opcode was illegal (12-15)
//   out_tag              in_tag of this operation, returned unchanged
`timescale 1ns/1ps
module alu_pipe_param #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  // Signed overflow of x+y: the operands agree in sign and the sum does not.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[MSB] == y[MSB]) && (s[MSB] != x[MSB]);
  endfunction

  // Signed overflow of x-y: the operands differ in sign and the result
  // takes the sign of y.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] d);
    return (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]);
  endfunction

  logic             vld_p0_q, vld_p1_q, vld_p2_q;
  logic             ld_p0, ld_p1, ld_p2;

  logic [3:0]       op_p0_q;
  logic [WIDTH-1:0] a_p0_q, b_p0_q;
  logic [TAG_W-1:0] tag_p0_q;

  logic [WIDTH-1:0] res_p1_q, res_p1_d;
  logic             z_p1_q, n_p1_q, c_p1_q, v_p1_q, err_p1_q;
  logic             z_p1_d, n_p1_d, c_p1_d, v_p1_d, err_p1_d;
  logic [TAG_W-1:0] tag_p1_q;

  logic [WIDTH-1:0] res_p2_q;
  logic             z_p2_q, n_p2_q, c_p2_q, v_p2_q, err_p2_q;
  logic [TAG_W-1:0] tag_p2_q;

  logic signed [WIDTH-1:0] a_s_p0, b_s_p0;
  logic [WIDTH:0]          sum_ext, dif_ext;
  logic [WIDTH-1:0]        zn_src;

  // Ready chain, evaluated from the output backwards. A stage loads when it
  // is empty or when the stage after it is loading.
  assign ld_p2    = !vld_p2_q || out_ready;
  assign ld_p1    = !vld_p1_q || ld_p2;
  assign ld_p0    = !vld_p0_q || ld_p1;
  assign in_ready = ld_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (ld_p0) vld_p0_q <= in_valid;
      if (ld_p1) vld_p1_q <= vld_p0_q;
      if (ld_p2) vld_p2_q <= vld_p1_q;
    end
  end

  // ---- S1: operand capture ----
  always_ff @(posedge clk) begin
    if (ld_p0) begin
      op_p0_q  <= op_code;
      a_p0_q   <= a;
      b_p0_q   <= b;
      tag_p0_q <= in_tag;
    end
  end

  // ---- S2: execute ----
  assign a_s_p0  = a_p0_q;
  assign b_s_p0  = b_p0_q;
  assign sum_ext = {1'b0, a_p0_q} + {1'b0, b_p0_q};
  assign dif_ext = {1'b0, a_p0_q} - {1'b0, b_p0_q};

  always_comb begin
    res_p1_d = '0;
    c_p1_d   = 1'b0;
    v_p1_d   = 1'b0;
    err_p1_d = 1'b0;
    case (op_p0_q)
      OP_ADD: begin
        res_p1_d = sum_ext[MSB:0];
        c_p1_d   = sum_ext[WIDTH];
        v_p1_d   = add_ovf(a_s_p0, b_s_p0, sum_ext[MSB:0]);
      end
      OP_SUB: begin
        res_p1_d = dif_ext[MSB:0];
        c_p1_d   = dif_ext[WIDTH];
        v_p1_d   = sub_ovf(a_s_p0, b_s_p0, dif_ext[MSB:0]);
      end
      OP_AND: res_p1_d = a_p0_q & b_p0_q;
      OP_OR:  res_p1_d = a_p0_q | b_p0_q;
      OP_XOR: res_p1_d = a_p0_q ^ b_p0_q;
      OP_NOT: res_p1_d = ~a_p0_q;
      OP_SHL: begin
        res_p1_d = {a_p0_q[MSB-1:0], 1'b0};
        c_p1_d   = a_p0_q[MSB];
      end
      OP_SHR: begin
        res_p1_d = {1'b0, a_p0_q[MSB:1]};
        c_p1_d   = a_p0_q[0];
      end
      OP_SRA: begin
        res_p1_d = a_s_p0 >>> 1;
        c_p1_d   = a_p0_q[0];
      end
      OP_ROL: begin
        res_p1_d = {a_p0_q[MSB-1:0], a_p0_q[MSB]};
        c_p1_d   = a_p0_q[MSB];
      end
      OP_ROR: begin
        res_p1_d = {a_p0_q[0], a_p0_q[MSB:1]};
        c_p1_d   = a_p0_q[0];
      end
      // CMP returns A unchanged but reports the flags of A-B.
      OP_CMP: begin
        res_p1_d = a_p0_q;
        c_p1_d   = dif_ext[WIDTH];
        v_p1_d   = sub_ovf(a_s_p0, b_s_p0, dif_ext[MSB:0]);
      end
      default: err_p1_d = 1'b1;
    endcase
    zn_src = (op_p0_q == OP_CMP) ? dif_ext[MSB:0] : res_p1_d;
    z_p1_d = (zn_src == '0);
    n_p1_d = zn_src[MSB];
  end

  always_ff @(posedge clk) begin
    if (ld_p1) begin
      res_p1_q <= res_p1_d;
      z_p1_q   <= z_p1_d;
      n_p1_q   <= n_p1_d;
      c_p1_q   <= c_p1_d;
      v_p1_q   <= v_p1_d;
      err_p1_q <= err_p1_d;
      tag_p1_q <= tag_p0_q;
    end
  end

  // ---- S3: output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_p2_q <= '0;
      z_p2_q   <= 1'b0;
      n_p2_q   <= 1'b0;
      c_p2_q   <= 1'b0;
      v_p2_q   <= 1'b0;
      err_p2_q <= 1'b0;
      tag_p2_q <= '0;
    end else if (ld_p2) begin
      res_p2_q <= res_p1_q;
      z_p2_q   <= z_p1_q;
      n_p2_q   <= n_p1_q;
      c_p2_q   <= c_p1_q;
      v_p2_q   <= v_p1_q;
      err_p2_q <= err_p1_q;
      tag_p2_q <= tag_p1_q;
    end
  end

  assign out_valid = vld_p2_q;
  assign result    = res_p2_q;
  assign flag_z    = z_p2_q;
  assign flag_n    = n_p2_q;
  assign flag_c    = c_p2_q;
  assign flag_v    = v_p2_q;
  assign out_err   = err_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
- Parametrised, flow-controlled pipelined ALU and the next generation of the team's fixed 8-bit pipelined ALU.
- Adds configurable width, a valid/ready handshake with full backpressure, status flags, an extended opcode set, illegal-op detection and a pass-through tag.
- Sits between an operand issue source and a result consumer. It sustains one operation per clock when the consumer is ready.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)
- TAG_W, 4, width of the user tag carried alongside each operation (>=1)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented on op_code/a/b/in_tag
- in_ready  output  1  block accepts the operation this cycle
- op_code  input  4  operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- in_tag  input  TAG_W  user tag, returned unchanged with the result
- out_valid  output  1  result/flags/tag valid
- out_ready  input  1  consumer accepts the result this cycle
- result  output  WIDTH  operation result
- flag_z  output  1  result == 0
- flag_n  output  1  result[WIDTH-1]
- flag_c  output  1  carry/borrow/shifted-out bit
- flag_v  output  1  signed overflow
- out_err  output  1  illegal opcode
- out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset is asynchronous, active-high, and can occur mid-operation.
  - Clears all stage valid bits, so out_valid=0 and every in-flight operation is discarded.
  - result, flags, out_err and out_tag reset to 0.
  - in_ready=1 from the first cycle after reset deasserts.
- Pipeline structure, three stages:
  - S1 registers the inputs.
  - S2 executes and registers result, flags and err.
  - S3 is the output register driving all out_* ports.
  - Each stage holds a valid bit.
- Advance rules:
  - S3 loads when !v3 || out_ready.
  - S2 moves to S3 when S3 loads.
  - S1 moves to S2 when !v2 || S3 loads.
  - in_ready = !v1 || (S1 moves). The ready chain is combinational; there are no bubbles.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - With out_ready held at 1, latency is 3 cycles from input transfer to out_valid, with throughput 1/cycle.
- While out_valid=1 and out_ready=0:
  - All out_* ports hold stable.
  - The pipeline fills; in_ready drops once S1, S2 and S3 are all valid.
  - Nothing is dropped or duplicated, and ordering is strictly preserved.
- A stage that is not advancing keeps its contents. A stage whose valid bit is 0 may load anything.
- Opcodes (shifts are by 1):
  - 0 ADD: A+B. C = carry out. V = signed overflow.
  - 1 SUB: A-B. C = borrow (1 when A<B unsigned). V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=0, V=0.
  - 5 NOT: ~A. C=0, V=0.
  - 6 SHL: A<<1, C=A[WIDTH-1]. 7 SHR logical: A>>1, C=A[0]. 8 SRA arithmetic: A>>>1, C=A[0]. V=0 for all shifts.
  - 9 ROL and 10 ROR: rotate A; C = the bit rotated around. V=0.
  - 11 CMP: flags as SUB, but result = A.
  - 12-15 illegal: result=0, flag_c=0, flag_v=0, out_err=1. The operation still flows through the pipeline with its tag.
- Z and N are always computed from the final result. For CMP, Z and N are computed from A-B instead.
- Results wrap modulo 2^WIDTH; B is ignored for ops 5-10.

Test Plan:
- Reset, then ADD a=8'h7F, b=8'h01, tag 3, out_ready=1:
  - result 8'h80, n=1, v=1, c=0, z=0, out_tag 3.
  - out_valid asserts exactly 3 cycles after the transfer.
- Back-to-back SUB 5-5, SUB 3-5, ADD FF+01 on consecutive cycles:
  - Results 00 (z=1, c=0), FE (c=1, n=1), 00 (c=1, z=1) on 3 consecutive cycles, with in_ready constantly 1.
- Backpressure:
  - Drive 5 ops (tags 0-4) with out_ready=0: in_ready drops after 3 accepted, and the outputs hold the tag 0 result stable.
  - Release out_ready: tags 0-4 emerge in order with no loss.
- Shifts and rotates on a=8'b1000_0001:
  - SHL gives 02 with c=1.
  - SRA gives C0 with c=1.
  - ROR gives C0 with c=1.
  - ROL gives 03 with c=1.
- CMP and illegal ops:
  - CMP a=4, b=9 gives result 04, c=1, n=1, z=0.
  - op 13 gives result 0, out_err=1, with its tag preserved.
- Asynchronous reset asserted with 3 ops in flight and out_ready=0:
  - out_valid=0 immediately.
  - No stale result appears after reset is released.
  - Run the same checks with WIDTH=16: ADD FFFF+0001 gives 0000 with c=1, z=1.
